// File: rtl/ram_port_arbiter.sv
// Two-requester arbiter in front of a simple dual-port RAM (one write port,
// one 1-cycle registered-read port). Each RAM port has its own round-robin
// arbiter; read responses are steered back to their owner through a
// two-stage valid/owner tag pipeline.

// Round-robin arbiter for two requesters; ptr names the requester that wins a tie.
module ram_port_arbiter_rr (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] valid,
    output logic [1:0] grant
);
    logic ptr;

    // Grant a lone requester outright; on a tie the pointer decides. Nothing is granted in reset.
    always_comb begin
        grant = 2'b00;
        if (!rst) begin
            if (valid[0] && (!valid[1] || !ptr))
                grant[0] = 1'b1;
            else if (valid[1])
                grant[1] = 1'b1;
        end
    end

    // After a grant, point at the other requester; with no grant, hold.
    always_ff @(posedge clk) begin
        if (rst)
            ptr <= 1'b0;
        else if (grant[0])
            ptr <= 1'b1;
        else if (grant[1])
            ptr <= 1'b0;
    end
endmodule

module ram_port_arbiter #(
    parameter int WORDS_BITS = 8,
    parameter int ADDR_BITS  = 9
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req0_wr_valid,
    input  logic [ADDR_BITS-1:0]  req0_wr_addr,
    input  logic [WORDS_BITS-1:0] req0_wr_data,
    output logic                  req0_wr_ready,
    input  logic                  req1_wr_valid,
    input  logic [ADDR_BITS-1:0]  req1_wr_addr,
    input  logic [WORDS_BITS-1:0] req1_wr_data,
    output logic                  req1_wr_ready,
    input  logic                  req0_rd_valid,
    input  logic [ADDR_BITS-1:0]  req0_rd_addr,
    output logic                  req0_rd_ready,
    output logic                  req0_rd_data_valid,
    output logic [WORDS_BITS-1:0] req0_rd_data,
    input  logic                  req1_rd_valid,
    input  logic [ADDR_BITS-1:0]  req1_rd_addr,
    output logic                  req1_rd_ready,
    output logic                  req1_rd_data_valid,
    output logic [WORDS_BITS-1:0] req1_rd_data,
    output logic                  ram_wr_we,
    output logic [ADDR_BITS-1:0]  ram_wr_addr,
    output logic [WORDS_BITS-1:0] ram_wr_din,
    output logic [ADDR_BITS-1:0]  ram_rd_addr,
    input  logic [WORDS_BITS-1:0] ram_rd_dout
);
    logic [1:0] wr_gnt;
    logic [1:0] rd_gnt;
    // [0]: read issued to the RAM this cycle, [1]: RAM data valid this cycle
    logic [1:0] rd_vld_pipe;
    logic [1:0] rd_own_pipe;

    ram_port_arbiter_rr u_wr_arb (
        .clk   (clk),
        .rst   (rst),
        .valid ({req1_wr_valid, req0_wr_valid}),
        .grant (wr_gnt)
    );

    ram_port_arbiter_rr u_rd_arb (
        .clk   (clk),
        .rst   (rst),
        .valid ({req1_rd_valid, req0_rd_valid}),
        .grant (rd_gnt)
    );

    assign req0_wr_ready = wr_gnt[0];
    assign req1_wr_ready = wr_gnt[1];
    assign req0_rd_ready = rd_gnt[0];
    assign req1_rd_ready = rd_gnt[1];

    // Register the granted write; the strobe lasts exactly the cycle after acceptance.
    always_ff @(posedge clk) begin
        if (rst) begin
            ram_wr_we   <= 1'b0;
            ram_wr_addr <= '0;
            ram_wr_din  <= '0;
        end else begin
            ram_wr_we <= |wr_gnt;
            if (wr_gnt[0]) begin
                ram_wr_addr <= req0_wr_addr;
                ram_wr_din  <= req0_wr_data;
            end else if (wr_gnt[1]) begin
                ram_wr_addr <= req1_wr_addr;
                ram_wr_din  <= req1_wr_data;
            end
        end
    end

    // Register the granted read address and carry valid/owner alongside the RAM's read latency.
    always_ff @(posedge clk) begin
        if (rst) begin
            ram_rd_addr <= '0;
            rd_vld_pipe <= '0;
            rd_own_pipe <= '0;
        end else begin
            if (rd_gnt[0])
                ram_rd_addr <= req0_rd_addr;
            else if (rd_gnt[1])
                ram_rd_addr <= req1_rd_addr;
            rd_vld_pipe <= {rd_vld_pipe[0], |rd_gnt};
            rd_own_pipe <= {rd_own_pipe[0], rd_gnt[1]};
        end
    end

    assign req0_rd_data_valid = rd_vld_pipe[1] & ~rd_own_pipe[1];
    assign req1_rd_data_valid = rd_vld_pipe[1] &  rd_own_pipe[1];
    assign req0_rd_data       = ram_rd_dout;
    assign req1_rd_data       = ram_rd_dout;
endmodule

// File: tb/tb_ram_port_arbiter.sv
// Bench for ram_port_arbiter: a behavioural RAM plus a transaction-level
// model (tie winner = requester not granted last, memory image, per-cycle
// expected response slots) checked every cycle under directed and random stimulus.
module tb_ram_port_arbiter;
    localparam int WB = 8;
    localparam int AB = 9;

    logic          clk = 1'b0;
    logic          rst;
    logic          req0_wr_valid, req1_wr_valid, req0_rd_valid, req1_rd_valid;
    logic [AB-1:0] req0_wr_addr, req1_wr_addr, req0_rd_addr, req1_rd_addr;
    logic [WB-1:0] req0_wr_data, req1_wr_data;
    logic          req0_wr_ready, req1_wr_ready, req0_rd_ready, req1_rd_ready;
    logic          req0_rd_data_valid, req1_rd_data_valid;
    logic [WB-1:0] req0_rd_data, req1_rd_data;
    logic          ram_wr_we;
    logic [AB-1:0] ram_wr_addr, ram_rd_addr;
    logic [WB-1:0] ram_wr_din, ram_rd_dout;

    always #5 clk = ~clk;

    ram_port_arbiter #(.WORDS_BITS(WB), .ADDR_BITS(AB)) dut (
        .clk(clk), .rst(rst),
        .req0_wr_valid(req0_wr_valid), .req0_wr_addr(req0_wr_addr), .req0_wr_data(req0_wr_data),
        .req0_wr_ready(req0_wr_ready),
        .req1_wr_valid(req1_wr_valid), .req1_wr_addr(req1_wr_addr), .req1_wr_data(req1_wr_data),
        .req1_wr_ready(req1_wr_ready),
        .req0_rd_valid(req0_rd_valid), .req0_rd_addr(req0_rd_addr), .req0_rd_ready(req0_rd_ready),
        .req0_rd_data_valid(req0_rd_data_valid), .req0_rd_data(req0_rd_data),
        .req1_rd_valid(req1_rd_valid), .req1_rd_addr(req1_rd_addr), .req1_rd_ready(req1_rd_ready),
        .req1_rd_data_valid(req1_rd_data_valid), .req1_rd_data(req1_rd_data),
        .ram_wr_we(ram_wr_we), .ram_wr_addr(ram_wr_addr), .ram_wr_din(ram_wr_din),
        .ram_rd_addr(ram_rd_addr), .ram_rd_dout(ram_rd_dout)
    );

    // Registered-read RAM, read-before-write; cleared by reset so contents are known.
    logic [WB-1:0] mem [1<<AB];
    always @(posedge clk) begin
        ram_rd_dout <= mem[ram_rd_addr];
        if (rst) begin
            for (int i = 0; i < (1<<AB); i++) mem[i] <= '0;
        end else if (ram_wr_we) begin
            mem[ram_wr_addr] <= ram_wr_din;
        end
    end

    // Stimulus for the next cycle
    logic          s_rst;
    logic [1:0]    s_wv, s_rv;
    logic [AB-1:0] s_wa [2];
    logic [AB-1:0] s_ra [2];
    logic [WB-1:0] s_wd [2];

    // Reference model state
    int            cyc = 0;
    int            n_tests = 0;
    int            n_fail = 0;
    logic          wpref, rpref;
    logic          exp_we, zero_chk;
    logic [AB-1:0] exp_waddr, exp_raddr;
    logic [WB-1:0] exp_wdin;
    logic [WB-1:0] mem_m [1<<AB];
    logic          resp_v [4];
    logic          resp_own [4];
    logic [WB-1:0] resp_dat [4];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
        end
    endtask

    // Lone requester wins; on a tie the preferred one wins.
    function automatic logic [1:0] pick(input logic [1:0] v, input logic pref);
        if (v == 2'b11) return pref ? 2'b10 : 2'b01;
        return v;
    endfunction

    task automatic model_reset();
        exp_we = 1'b0; exp_waddr = '0; exp_wdin = '0; exp_raddr = '0;
        zero_chk = 1'b1; wpref = 1'b0; rpref = 1'b0;
        for (int i = 0; i < 4; i++) resp_v[i] = 1'b0;
        for (int i = 0; i < (1<<AB); i++) mem_m[i] = '0;
    endtask

    task automatic idle_stim();
        s_rst = 1'b0; s_wv = 2'b00; s_rv = 2'b00;
    endtask

    // One clock: check this cycle's outputs, drive stimulus, check readies, step the model.
    task automatic cycle();
        int         sl;
        logic [1:0] wg, rg;
        logic       wi, ri;
        @(negedge clk);
        chk("ram_wr_we", ram_wr_we, exp_we);
        if (exp_we || zero_chk) begin
            chk("ram_wr_addr", ram_wr_addr, exp_waddr);
            chk("ram_wr_din", ram_wr_din, exp_wdin);
        end
        chk("ram_rd_addr", ram_rd_addr, exp_raddr);
        sl = cyc % 4;
        chk("rd0_valid", req0_rd_data_valid, resp_v[sl] && !resp_own[sl]);
        chk("rd1_valid", req1_rd_data_valid, resp_v[sl] && resp_own[sl]);
        if (resp_v[sl])
            chk(resp_own[sl] ? "rd1_data" : "rd0_data",
                resp_own[sl] ? req1_rd_data : req0_rd_data, resp_dat[sl]);
        resp_v[sl] = 1'b0;

        rst = s_rst;
        req0_wr_valid = s_wv[0]; req0_wr_addr = s_wa[0]; req0_wr_data = s_wd[0];
        req1_wr_valid = s_wv[1]; req1_wr_addr = s_wa[1]; req1_wr_data = s_wd[1];
        req0_rd_valid = s_rv[0]; req0_rd_addr = s_ra[0];
        req1_rd_valid = s_rv[1]; req1_rd_addr = s_ra[1];
        #1;
        wg = s_rst ? 2'b00 : pick(s_wv, wpref);
        rg = s_rst ? 2'b00 : pick(s_rv, rpref);
        chk("req0_wr_ready", req0_wr_ready, wg[0]);
        chk("req1_wr_ready", req1_wr_ready, wg[1]);
        chk("req0_rd_ready", req0_rd_ready, rg[0]);
        chk("req1_rd_ready", req1_rd_ready, rg[1]);

        @(posedge clk);
        cyc++;
        if (s_rst) begin
            model_reset();
        end else begin
            wi = wg[1];
            ri = rg[1];
            if (|rg) begin
                sl = (cyc + 1) % 4;
                resp_v[sl] = 1'b1;
                resp_own[sl] = ri;
                resp_dat[sl] = mem_m[s_ra[ri]];
                exp_raddr = s_ra[ri];
                rpref = ~ri;
            end
            exp_we = |wg;
            if (|wg) begin
                exp_waddr = s_wa[wi];
                exp_wdin = s_wd[wi];
                mem_m[s_wa[wi]] = s_wd[wi];
                wpref = ~wi;
                zero_chk = 1'b0;
            end
        end
    endtask

    task automatic do_reset();
        idle_stim();
        s_rst = 1'b1;
        s_wv = 2'b11; s_rv = 2'b11;   // readies must stay low anyway
        cycle();
        idle_stim();
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            s_wa[i] = '0; s_ra[i] = '0; s_wd[i] = '0;
        end
        idle_stim();
        rst = 1'b1;
        req0_wr_valid = 0; req1_wr_valid = 0; req0_rd_valid = 0; req1_rd_valid = 0;
        req0_wr_addr = '0; req1_wr_addr = '0; req0_rd_addr = '0; req1_rd_addr = '0;
        req0_wr_data = '0; req1_wr_data = '0;
        model_reset();
        repeat (3) @(posedge clk);
        do_reset();

        // Single requester write then read back
        s_wv[0] = 1; s_wa[0] = 3; s_wd[0] = 8'h5A; cycle();
        idle_stim(); cycle();
        s_rv[0] = 1; s_ra[0] = 3; cycle();
        idle_stim(); repeat (3) cycle();

        // Write contention right after reset: req0, req1, req0, req1
        do_reset();
        s_wv = 2'b11; s_wa[0] = 20; s_wd[0] = 8'hA0; s_wa[1] = 21; s_wd[1] = 8'hB1;
        repeat (4) cycle();
        idle_stim(); repeat (2) cycle();

        // Same-edge read/write to one address returns old data; one edge later, new data
        s_wv[0] = 1; s_wa[0] = 7; s_wd[0] = 8'h11; cycle();
        idle_stim(); cycle();
        s_wv[1] = 1; s_wa[1] = 7; s_wd[1] = 8'h22; s_rv[0] = 1; s_ra[0] = 7; cycle();
        idle_stim(); s_rv[1] = 1; s_ra[1] = 7; cycle();
        idle_stim(); repeat (3) cycle();

        // Interleaved continuous reads over 0..3 and 8..11
        for (int i = 0; i < 4; i++) begin
            s_wv = 2'b11;
            s_wa[0] = AB'(i);     s_wd[0] = 8'(8'h30 + i);
            s_wa[1] = AB'(8 + i); s_wd[1] = 8'(8'h80 + i);
            cycle(); cycle();
        end
        idle_stim();
        for (int i = 0; i < 8; i++) begin
            s_rv = 2'b11; s_ra[0] = AB'(i % 4); s_ra[1] = AB'(8 + i % 4);
            cycle();
        end
        idle_stim(); repeat (3) cycle();

        // Reset one cycle after a read acceptance: no response, pointers back to req0
        s_rv[0] = 1; s_ra[0] = 9; s_rv[1] = 1; s_ra[1] = 10; cycle();
        idle_stim(); s_rst = 1; cycle();
        idle_stim(); cycle();
        s_wv = 2'b11; s_rv = 2'b11; cycle();
        idle_stim(); repeat (3) cycle();

        // Idle hold after a req1 grant on each port
        s_wv[1] = 1; s_wa[1] = 40; s_wd[1] = 8'h44; s_rv[1] = 1; s_ra[1] = 41; cycle();
        idle_stim(); repeat (10) cycle();
        s_wv = 2'b11; s_rv = 2'b11; cycle();
        idle_stim(); repeat (3) cycle();

        // Random traffic on a small address range to provoke hazards
        for (int i = 0; i < 400; i++) begin
            s_rst = 1'b0;
            s_wv = 2'($urandom_range(0, 3));
            s_rv = 2'($urandom_range(0, 3));
            for (int j = 0; j < 2; j++) begin
                s_wa[j] = AB'($urandom_range(0, 15));
                s_ra[j] = AB'($urandom_range(0, 15));
                s_wd[j] = WB'($urandom);
            end
            cycle();
        end
        idle_stim(); repeat (4) cycle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/ram_port_arbiter.md
RAM_PORT_ARBITER -- requirements
Module: ram_port_arbiter

Interface
REQ-001 SHALL have parameter WORDS_BITS, default 8: data width in bits.
REQ-002 SHALL have parameter ADDR_BITS, default 9: RAM address width in bits.
REQ-003 SHALL have port clk, input, 1: single clock for all logic; posedge.
REQ-004 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-005 SHALL have ports reqN_wr_valid (input, 1), reqN_wr_addr (input, ADDR_BITS) and reqN_wr_data (input, WORDS_BITS), for N = 0 and N = 1: write request from requester N.
REQ-006 SHALL have port reqN_wr_ready, output, 1, for N = 0, 1: write accepted this cycle.
REQ-007 SHALL have ports reqN_rd_valid (input, 1) and reqN_rd_addr (input, ADDR_BITS), for N = 0, 1: read request.
REQ-008 SHALL have port reqN_rd_ready, output, 1, for N = 0, 1: read accepted this cycle.
REQ-009 SHALL have ports reqN_rd_data_valid (output, 1) and reqN_rd_data (output, WORDS_BITS), for N = 0, 1: read response.
REQ-010 SHALL have RAM write-side outputs: ram_wr_we (1), ram_wr_addr (ADDR_BITS), ram_wr_din (WORDS_BITS).
REQ-011 SHALL have RAM read-side output ram_rd_addr (ADDR_BITS) and input ram_rd_dout (WORDS_BITS).
- The RAM is a 1-cycle registered-read memory on clk.

Function
REQ-012 SHALL arbitrate the write port and the read port independently; each port grants at most one requester per cycle.
REQ-013 SHALL accept a transfer on a cycle where valid and ready are both high at the posedge.
REQ-014 SHALL compute ready combinationally from the valid inputs and the port's priority pointer; ready SHALL NOT depend on ready.
REQ-015 SHALL handle a single valid requester: grant it regardless of the pointer.
REQ-016 SHALL handle both requesters valid: grant the one the pointer selects.
REQ-017 SHALL update the pointer after any grant so that it selects the other requester (round-robin); with no grant, the pointer SHALL hold.
REQ-018 SHALL keep ready low for every requester whose valid is low.
REQ-019 SHALL, for a write accepted at edge E, drive ram_wr_we = 1 with the registered addr/data during the cycle after E; otherwise ram_wr_we = 0.
REQ-020 SHALL, for a read accepted at edge E, register ram_rd_addr at E (it holds its value when idle).
REQ-021 SHALL, for a read accepted at edge E, assert the granted reqN_rd_data_valid for exactly one cycle, starting at E+2 (latency 2 clocks).
REQ-022 SHALL drive reqN_rd_data = ram_rd_dout for both requesters; the content is only meaningful while the matching rd_data_valid is high.
REQ-023 SHALL keep an owner tag of 2 pipeline stages, so that back-to-back reads alternating between requesters return in order, one per cycle.
REQ-024 SHALL NOT forward write data: a read and a write to the same address accepted at the same edge return the old data.
REQ-025 SHALL ensure a read accepted one or more edges after a write to the same address returns the new data.
REQ-026 SHALL sustain full throughput: one write and one read per cycle with no bubbles.
REQ-027 SHALL pass addresses and data unmodified; there is no address wrap or width conversion.

Reset
REQ-028 SHALL, while rst is high at a posedge, clear ram_wr_we, ram_wr_addr, ram_wr_din, ram_rd_addr, both rd_data_valid outputs and the tag pipeline.
REQ-029 SHALL set both priority pointers to requester 0 on reset.
REQ-030 SHALL force all ready outputs to 0 while rst is high.
REQ-031 SHALL, when reset is applied mid-operation, discard reads in flight: no rd_data_valid is asserted after the reset edge.
REQ-032 SHALL allow a write registered before the reset edge to be dropped (ram_wr_we is cleared).

Verification
REQ-033 Single requester: req0 writes 0x5A at address 3, then req0 reads address 3 two cycles later -> req0_rd_data_valid is high for 1 cycle at acceptance+2 with data 0x5A; req1 sees no valid.
REQ-034 Contention: both requesters keep wr_valid high for 4 cycles after reset -> grants go req0, req1, req0, req1; ram_wr_we stays high for 4 consecutive cycles.
REQ-035 Same-cycle RAW: address 7 holds 0x11; a write of 0x22 and a read of address 7 are accepted at the same edge -> the read returns 0x11; a read one cycle later returns 0x22.
REQ-036 Interleaved reads: req0 and req1 both read continuously, at addresses 0..3 and 8..11 -> responses alternate between requesters every cycle, each with correct data and no lost or duplicated valid.
REQ-037 Reset mid-flight: rst is asserted one cycle after a read acceptance -> no rd_data_valid follows; after release, the first contention grant goes to req0.
REQ-038 Idle hold: no valids for 10 cycles after a req1 grant -> the pointer still selects req0; ram_wr_we stays 0 and ram_rd_addr is unchanged.
